cacheline_adapter: RTL and testbench
====================================

CACHELINE_ADAPTER -- requirements
Module: cacheline_adapter

Interface
REQ-001 Parameter: LINE_W, default 256, cache line width in bits.
REQ-002 Parameter: BEAT_W, default 64, memory burst beat width in bits; BEATS = LINE_W/BEAT_W = 4.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous assert, active-low (rst = 0 resets).
REQ-005 line_addr  input  32  cache-side line address.
REQ-006 line_read  input  1  cache-side line fill request; held until line_resp.
REQ-007 line_write  input  1  cache-side line writeback request; held until line_resp.
REQ-008 line_wdata  input  LINE_W  writeback line, stable while line_write is high.
REQ-009 line_rdata  output  LINE_W  assembled fill line.
REQ-010 line_resp  output  1  one-cycle completion pulse to the cache.
REQ-011 burst_addr  output  32  memory-side burst address, line-aligned.
REQ-012 burst_read  output  1  memory-side read burst request.
REQ-013 burst_write  output  1  memory-side write burst request.
REQ-014 burst_wdata  output  BEAT_W  current write beat.
REQ-015 burst_rdata  input  BEAT_W  current read beat, valid when burst_resp = 1.
REQ-016 burst_resp  input  1  memory-side beat acknowledge, one per beat.

Function
REQ-017 The FSM SHALL have states IDLE, READ, WRITE, DONE.
REQ-018 IDLE -> WRITE when line_write = 1; IDLE -> READ when line_read = 1 and line_write = 0 (writeback wins on simultaneous assertion).
REQ-019 On leaving IDLE, the block SHALL capture line_addr with bits [4:0] zeroed into burst_addr, capture line_wdata into a write shift register, and clear the 2-bit beat counter.
REQ-020 In READ, burst_read SHALL be 1; on each cycle with burst_resp = 1, burst_rdata SHALL be written into line_rdata[BEAT_W*cnt +: BEAT_W] and cnt incremented.
REQ-021 In WRITE, burst_write SHALL be 1 and burst_wdata SHALL equal line_wdata beat cnt (beat 0 = bits [63:0]); each burst_resp advances to the next beat.
REQ-022 burst_resp on beat cnt = 3 SHALL move READ/WRITE -> DONE; the counter wraps to 0.
REQ-023 burst_read and burst_write SHALL drop in the cycle DONE is entered, and never be 1 together.
REQ-024 In DONE, line_resp SHALL be 1 for exactly one cycle, line_rdata holds the full line, then -> IDLE.
REQ-025 Latency: line_resp asserts one cycle after the 4th burst_resp; minimum 6 cycles request to response (1 capture + 4 beats + 1 done).
REQ-026 burst_resp in IDLE or DONE SHALL be ignored.
REQ-027 burst_resp deasserted mid-burst SHALL stall the counter with burst_* outputs held.
REQ-028 line_rdata SHALL remain stable from DONE until the next READ's first beat.
REQ-029 A request still high in the cycle after line_resp SHALL be treated as a new request.

Reset
REQ-030 While rst = 0: state = IDLE, cnt = 0, line_resp = burst_read = burst_write = 0, burst_addr = 0, burst_wdata = 0, line_rdata = 0.
REQ-031 Reset mid-burst SHALL abort immediately with no line_resp; the first request after reset release SHALL start a fresh burst at beat 0.

Structure
REQ-032 The FSM state enum and constants LINE_W, BEAT_W, BEATS and offset width 5 SHALL live in the shared cache_types_pkg.
REQ-033 The block SHALL be a single module with no sub-modules; the beat counter and shift register are inline.

Verification
REQ-034 Read: line_read, line_addr = 0x0000_1234; memory returns 0x11..11, 0x22..22, 0x33..33, 0x44..44 -> burst_addr = 0x0000_1220, line_rdata = {0x44..44, 0x33..33, 0x22..22, 0x11..11}, single line_resp 6 cycles after request.
REQ-035 Write: line_write, line_wdata = {4{0xDEAD_BEEF_0000_000k}} for k = 0..3 -> burst_wdata beats in order k = 0,1,2,3, line_resp once, burst_write low afterward.
REQ-036 Simultaneous line_read = line_write = 1 -> WRITE burst first, then a READ burst after line_resp with the read still held.
REQ-037 Stalls: burst_resp only every 3rd cycle -> same read data as REQ-034, line_resp 13 cycles after request, outputs stable during stalls.
REQ-038 Reset asserted after beat 2 of a read -> all outputs 0 asynchronously, no line_resp; a new read after release completes correctly.

Source files
------------

// File: rtl/cache_types_pkg.sv
// Shared cache-side types and geometry for the line/burst adapter.
// Beat counter width follows from the number of beats per line.
package cache_types_pkg;
    localparam int LINE_W   = 256;
    localparam int BEAT_W   = 64;
    localparam int BEATS    = LINE_W / BEAT_W;
    localparam int OFFSET_W = 5;
    localparam int CNT_W    = $clog2(BEATS);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } state_t;
endpackage

// File: rtl/cacheline_adapter_if.sv
// Cache-side line port and memory-side burst port of the line adapter.
// The adapter uses the slave view; the cache/memory environment uses master.
interface cacheline_adapter_if #(
    parameter int LINE_W = cache_types_pkg::LINE_W,
    parameter int BEAT_W = cache_types_pkg::BEAT_W
);
    logic [31:0]       line_addr;
    logic              line_read;
    logic              line_write;
    logic [LINE_W-1:0] line_wdata;
    logic [LINE_W-1:0] line_rdata;
    logic              line_resp;

    logic [31:0]       burst_addr;
    logic              burst_read;
    logic              burst_write;
    logic [BEAT_W-1:0] burst_wdata;
    logic [BEAT_W-1:0] burst_rdata;
    logic              burst_resp;

    modport slave (
        input  line_addr, line_read, line_write, line_wdata, burst_rdata, burst_resp,
        output line_rdata, line_resp, burst_addr, burst_read, burst_write, burst_wdata
    );

    modport master (
        output line_addr, line_read, line_write, line_wdata, burst_rdata, burst_resp,
        input  line_rdata, line_resp, burst_addr, burst_read, burst_write, burst_wdata
    );
endinterface

// File: rtl/cacheline_adapter.sv
// Converts whole-line cache fills/writebacks into four-beat memory bursts.
// Writebacks take priority over fills when both are requested together.
module cacheline_adapter #(
    parameter int LINE_W = cache_types_pkg::LINE_W,
    parameter int BEAT_W = cache_types_pkg::BEAT_W
) (
    input  logic               clk,
    input  logic               rst,
    cacheline_adapter_if.slave bus
);
    import cache_types_pkg::*;

    localparam logic [31:0] OFFSET_MASK = 32'((1 << OFFSET_W) - 1);

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [LINE_W-1:0] wsr;
    logic [LINE_W-1:0] rdata;
    logic [31:0]       addr;
    logic              beat_ack;
    logic              last_beat;

    // Memory acknowledges only count while a burst is actually in flight.
    assign beat_ack  = bus.burst_resp && ((state == READ) || (state == WRITE));
    assign last_beat = beat_ack && (cnt == CNT_W'(BEATS - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.line_write) begin
                    state_nxt = WRITE;
                end else if (bus.line_read) begin
                    state_nxt = READ;
                end
            end
            READ, WRITE: begin
                if (last_beat) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The shift register always presents the current write beat in its low word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            wsr   <= '0;
            rdata <= '0;
            addr  <= '0;
        end else if (state == IDLE) begin
            if (bus.line_write || bus.line_read) begin
                addr <= bus.line_addr & ~OFFSET_MASK;
                wsr  <= bus.line_wdata;
                cnt  <= '0;
            end
        end else if (beat_ack) begin
            cnt <= cnt + 1'b1;
            if (state == READ) begin
                rdata[int'(cnt)*BEAT_W +: BEAT_W] <= bus.burst_rdata;
            end else begin
                wsr <= wsr >> BEAT_W;
            end
        end
    end

    assign bus.burst_read  = (state == READ);
    assign bus.burst_write = (state == WRITE);
    assign bus.line_resp   = (state == DONE);
    assign bus.burst_addr  = addr;
    assign bus.burst_wdata = wsr[BEAT_W-1:0];
    assign bus.line_rdata  = rdata;
endmodule

// File: tb/tb_cacheline_adapter.sv
// Scoreboard bench for cacheline_adapter: memory model replays queued beats,
// line monitor checks each completion against the queued expected line.
module tb_cacheline_adapter;
    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [63:0] data;
    } beat_t;

    typedef struct packed {
        logic         wr;
        logic [255:0] data;
    } line_t;

    logic clk;
    logic rst;

    cacheline_adapter_if bus ();

    cacheline_adapter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    beat_t beat_q[$];
    line_t line_q[$];
    int    n_chk = 0;
    int    n_bad = 0;
    bit    stall = 0;
    bit    noise = 0;
    int    mk;
    beat_t mdl_e;
    line_t mon_l;

    logic [255:0] rd1_line;
    logic [255:0] rd2_line;
    logic [255:0] rd3_line;
    logic [255:0] wd1_line;
    logic [255:0] wd2_line;
    int           lat;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] fill8(input logic [7:0] b);
        return {8{b}};
    endfunction

    task automatic push_beat(input logic wr, input logic [31:0] a, input logic [63:0] d);
        beat_t e;
        e.wr   = wr;
        e.addr = a;
        e.data = d;
        beat_q.push_back(e);
    endtask

    task automatic push_line(input logic wr, input logic [255:0] d);
        line_t l;
        l.wr   = wr;
        l.data = d;
        line_q.push_back(l);
    endtask

    task automatic push_read(input logic [31:0] a, input logic [255:0] line);
        for (int i = 0; i < 4; i++) push_beat(1'b0, a, line[i*64 +: 64]);
        push_line(1'b0, line);
    endtask

    task automatic push_write(input logic [31:0] a, input logic [255:0] line);
        for (int i = 0; i < 4; i++) push_beat(1'b1, a, line[i*64 +: 64]);
        push_line(1'b1, '0);
    endtask

    // Returns the request-to-response latency counting both end cycles.
    task automatic wait_resp(output int cyc);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!bus.line_resp && n < 100);
        chk("resp_seen", bus.line_resp, 1'b1);
        cyc = n + 1;
    endtask

    task automatic do_req(input logic wr, input logic rd, input logic [31:0] a,
                          input logic [255:0] wd, output int cyc);
        @(negedge clk);
        bus.line_addr  = a;
        bus.line_wdata = wd;
        bus.line_write = wr;
        bus.line_read  = rd;
        wait_resp(cyc);
        bus.line_write = 1'b0;
        bus.line_read  = 1'b0;
        @(posedge clk);
        #1;
        chk("resp_1cyc", bus.line_resp, 1'b0);
    endtask

    // Memory model: acknowledges queued beats, checks address/direction/write data.
    initial begin
        bus.burst_resp  = 1'b0;
        bus.burst_rdata = '0;
        mk = 0;
        forever begin
            @(negedge clk);
            chk("rw_excl", bus.burst_read & bus.burst_write, 1'b0);
            if (rst && (bus.burst_read || bus.burst_write)) begin
                if (beat_q.size() == 0) begin
                    chk("beat_extra", 1'b1, 1'b0);
                    bus.burst_resp = 1'b0;
                end else begin
                    mdl_e = beat_q[0];
                    chk("baddr", bus.burst_addr, mdl_e.addr);
                    chk("bdir", bus.burst_write, mdl_e.wr);
                    if (mdl_e.wr) chk("bwdata", bus.burst_wdata, mdl_e.data);
                    bus.burst_resp = stall ? ((mk % 3) == 1) : 1'b1;
                    if (bus.burst_resp) begin
                        bus.burst_rdata = mdl_e.wr ? 64'h0 : mdl_e.data;
                        void'(beat_q.pop_front());
                    end else begin
                        bus.burst_rdata = {$urandom, $urandom};
                    end
                end
                mk++;
            end else begin
                mk = 0;
                bus.burst_resp  = noise;
                bus.burst_rdata = {$urandom, $urandom};
            end
        end
    end

    // Line monitor: every completion must match the oldest queued line.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.line_resp) begin
                if (line_q.size() == 0) begin
                    chk("resp_unexp", 1'b1, 1'b0);
                end else begin
                    mon_l = line_q.pop_front();
                    if (!mon_l.wr) chk("rdata", bus.line_rdata, mon_l.data);
                    chk("burst_drop", {bus.burst_read, bus.burst_write}, 2'b00);
                end
            end
        end
    end

    initial begin
        rd1_line = {fill8(8'h44), fill8(8'h33), fill8(8'h22), fill8(8'h11)};
        rd2_line = {fill8(8'hF0), fill8(8'h0F), fill8(8'h5A), fill8(8'hA5)};
        rd3_line = {fill8(8'h99), fill8(8'h88), fill8(8'h77), fill8(8'h66)};
        for (int k = 0; k < 4; k++) begin
            wd1_line[k*64 +: 64] = 64'hDEAD_BEEF_0000_0000 | 64'(k);
            wd2_line[k*64 +: 64] = 64'hCAFE_F00D_0000_0010 | 64'(k);
        end

        rst            = 1'b0;
        bus.line_addr  = '0;
        bus.line_read  = 1'b0;
        bus.line_write = 1'b0;
        bus.line_wdata = '0;
        #3;
        chk("rst_state_resp", bus.line_resp, 1'b0);
        chk("rst_state_rd", bus.burst_read, 1'b0);
        chk("rst_state_wr", bus.burst_write, 1'b0);
        chk("rst_state_addr", bus.burst_addr, 32'h0);
        chk("rst_state_wdata", bus.burst_wdata, 64'h0);
        chk("rst_state_rdata", bus.line_rdata, 256'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Plain fill
        push_read(32'h0000_1220, rd1_line);
        do_req(1'b0, 1'b1, 32'h0000_1234, '0, lat);
        chk("lat_read", lat, 6);

        // Writeback with stray acks while idle/done
        noise = 1'b1;
        push_write(32'h0000_5660, wd1_line);
        do_req(1'b1, 1'b0, 32'h0000_5678, wd1_line, lat);
        chk("lat_write", lat, 6);
        chk("rdata_hold", bus.line_rdata, rd1_line);
        chk("wr_low_after", bus.burst_write, 1'b0);

        // Simultaneous: writeback first, then the still-held fill
        push_write(32'h0000_9AA0, wd2_line);
        push_read(32'h0000_9AA0, rd2_line);
        @(negedge clk);
        bus.line_addr  = 32'h0000_9ABC;
        bus.line_wdata = wd2_line;
        bus.line_write = 1'b1;
        bus.line_read  = 1'b1;
        wait_resp(lat);
        chk("lat_both_wr", lat, 6);
        bus.line_write = 1'b0;
        @(posedge clk);
        #1;
        chk("resp_1cyc_both", bus.line_resp, 1'b0);
        wait_resp(lat);
        bus.line_read = 1'b0;
        @(posedge clk);
        #1;
        chk("resp_1cyc_held", bus.line_resp, 1'b0);
        noise = 1'b0;

        // Stalled fill: ack every third cycle
        stall = 1'b1;
        push_read(32'h0000_1220, rd1_line);
        do_req(1'b0, 1'b1, 32'h0000_1234, '0, lat);
        chk("lat_stall", lat, 13);
        stall = 1'b0;

        // Reset after two beats of a fill
        for (int i = 0; i < 4; i++) push_beat(1'b0, 32'h0000_2000, rd3_line[i*64 +: 64]);
        @(negedge clk);
        bus.line_addr = 32'h0000_2004;
        bus.line_read = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_rd", bus.burst_read, 1'b0);
        chk("arst_wr", bus.burst_write, 1'b0);
        chk("arst_resp", bus.line_resp, 1'b0);
        chk("arst_addr", bus.burst_addr, 32'h0);
        chk("arst_wdata", bus.burst_wdata, 64'h0);
        chk("arst_rdata", bus.line_rdata, 256'h0);
        bus.line_read = 1'b0;
        beat_q.delete();
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("arst_no_resp", bus.line_resp, 1'b0);
        end
        @(negedge clk);
        rst = 1'b1;
        push_read(32'h0000_2000, rd3_line);
        do_req(1'b0, 1'b1, 32'h0000_2004, '0, lat);
        chk("lat_after_rst", lat, 6);

        repeat (3) @(posedge clk);
        chk("beats_consumed", 32'(beat_q.size()), 32'd0);
        chk("lines_consumed", 32'(line_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
